// File: rtl/spram_stream_reader.sv
// Read sequencer for a single-port block RAM: streams a wrapping address
// window out over an AXI-Stream style master interface with TLAST.
module spram_stream_reader #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [WIDTH-1:0]      ram_dout,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  sent_q, sent_d;
  logic                  inflight_q;

  logic [WIDTH-1:0]      fifo_q [2];
  logic                  fifo_wr_q, fifo_rd_q;
  logic [1:0]            count_q, count_d;

  logic                  push, pop;
  logic [2:0]            occupancy;

  // Words already committed to the FIFO once this cycle's pop is accounted for.
  assign push      = inflight_q;
  assign m_valid   = (count_q != 2'd0);
  assign m_data    = fifo_q[fifo_rd_q];
  assign pop       = m_valid && m_ready;
  assign m_last    = m_valid && (sent_q == len_q - LEN_WIDTH'(1));
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign ram_en   = (state_q == ST_READ) && (issued_q < len_q) && (occupancy < 3'd2);
  assign ram_we   = 1'b0;
  assign ram_addr = ptr_q;
  assign busy     = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);

  // Next-state for the sequencer FSM, address pointer and word counters.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    issued_d = issued_q;
    sent_d   = sent_q;

    if (ram_en) begin
      issued_d = issued_q + LEN_WIDTH'(1);
      ptr_d    = (ptr_q == LastAddr) ? '0 : ptr_q + ADDR_WIDTH'(1);
    end
    if (pop) begin
      sent_d = sent_q + LEN_WIDTH'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d    = base_addr;
          len_d    = len;
          issued_d = '0;
          sent_d   = '0;
          state_d  = (len == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (ram_en && (issued_q == len_q - LEN_WIDTH'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last word can only be popped once every read has landed.
        if (!inflight_q && pop && m_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy next-state; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Sequencer and counter state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= ram_en;
    end
  end

  // Two-entry output FIFO capturing RAM data one cycle after each read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_q    <= '{default: '0};
      fifo_wr_q <= 1'b0;
      fifo_rd_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[fifo_wr_q] <= ram_dout;
        fifo_wr_q         <= ~fifo_wr_q;
      end
      if (pop) begin
        fifo_rd_q <= ~fifo_rd_q;
      end
      count_q <= count_d;
    end
  end

  // A push into a full FIFO without a pop would lose a word.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && (count_q == 2'd2)));

endmodule

// File: tb/tb_spram_stream_reader.sv
// Self-checking bench for spram_stream_reader: behavioural RAM plus a
// queue-based model of the expected word stream and handshake timing.
`timescale 1ns/1ps
module tb_spram_stream_reader;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned LW    = 11;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [LW-1:0]    len = '0;
  logic             busy, done, ram_en, ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_dout = '0;
  logic [WIDTH-1:0] m_data;
  logic             m_valid, m_last;
  logic             m_ready = 1'b0;

  logic [WIDTH-1:0] ram [DEPTH];
  bit               ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  int n_checks = 0;
  int n_fail   = 0;

  spram_stream_reader #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // Block RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_en) ram_dout <= ram[ram_addr];
  end

  task automatic preload_linear();
    for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i + 'h100);
  endtask

  // Runs one transfer. mode 0: ready always 1, 1: fixed ready pattern,
  // 2: random ready. poke re-asserts start while busy and during done.
  task automatic run_xfer(input int base, input int n, input int mode, input bit poke);
    int issued = 0;
    int popped = 0;
    int cyc = 1;
    int done_cyc = -1;
    int budget = 60 + 6 * n;
    bit stalled = 1'b0;
    bit exp_busy, exp_done;
    logic [WIDTH-1:0] held = '0;
    logic [WIDTH-1:0] exp_q [$];
    for (int k = 0; k < n; k++) exp_q.push_back(ram[(base + k) % DEPTH]);
    if (n == 0) done_cyc = 1;

    @(negedge clk);
    base_addr = AW'(base);
    len       = LW'(n);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      base_addr = AW'(700);
      len       = LW'(3);
    end

    while (cyc <= budget && !(done_cyc >= 0 && cyc > done_cyc + 2)) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ready_pat[(cyc - 1) % 6];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke) start = (cyc == 2 || cyc == 4);
      #1;

      exp_done = (cyc == done_cyc);
      exp_busy = (n != 0) && (done_cyc < 0 || cyc < done_cyc);
      n_checks++;
      if (done !== exp_done || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL status cyc %0d: done=%b busy=%b, want done=%b busy=%b", cyc, done, busy, exp_done, exp_busy);
      end
      n_checks++;
      if (ram_we !== 1'b0) begin
        n_fail++;
        $display("FAIL ram_we cyc %0d: got %b want 0", cyc, ram_we);
      end

      if (ram_en) begin
        n_checks++;
        if (issued >= n || ram_addr !== AW'((base + issued) % DEPTH)) begin
          n_fail++;
          $display("FAIL ram_addr cyc %0d: got %0d, read #%0d of %0d, want addr %0d", cyc, ram_addr, issued, n, (base + issued) % DEPTH);
        end
        issued++;
      end

      if (stalled) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          n_fail++;
          $display("FAIL stall_hold cyc %0d: valid=%b data=%h, want valid=1 data=%h", cyc, m_valid, m_data, held);
        end
      end

      if (m_valid) begin
        n_checks++;
        if (popped >= n) begin
          n_fail++;
          $display("FAIL extra_word cyc %0d: data=%h after %0d of %0d words", cyc, m_data, popped, n);
        end else if (m_data !== exp_q[popped] || m_last !== (popped == n - 1)) begin
          n_fail++;
          $display("FAIL data cyc %0d word %0d: got %h last=%b, want %h last=%b", cyc, popped, m_data, m_last, exp_q[popped], (popped == n - 1));
        end
        if (mode == 0 && popped < n) begin
          n_checks++;
          if (cyc != 3 + popped) begin
            n_fail++;
            $display("FAIL timing word %0d: got cycle %0d, want cycle %0d", popped, cyc, 3 + popped);
          end
        end
        if (m_ready) begin
          if (popped < n) popped++;
          if (popped == n && done_cyc < 0) done_cyc = cyc + 1;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = m_data;
        end
      end else if (m_last) begin
        n_checks++;
        n_fail++;
        $display("FAIL last_no_valid cyc %0d: m_last=1 with m_valid=0", cyc);
      end

      n_checks++;
      if (issued - popped > 2) begin
        n_fail++;
        $display("FAIL outstanding cyc %0d: got %0d reads beyond consumer, want <= 2", cyc, issued - popped);
      end

      if (poke && cyc == done_cyc) start = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    n_checks++;
    if (!(done_cyc >= 0 && cyc > done_cyc + 2)) begin
      n_fail++;
      $display("FAIL timeout: got %0d of %0d words in %0d cycles, want completion", popped, n, budget);
    end
    n_checks++;
    if (popped != n || issued != n) begin
      n_fail++;
      $display("FAIL word_count: got %0d words %0d reads, want %0d", popped, issued, n);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; m_ready = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({busy, done, ram_en, ram_we, m_valid, m_last} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000", {busy, done, ram_en, ram_we, m_valid, m_last});
    end
    n_checks++;
    if (m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", m_data);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();         run_xfer(0, 4, 0, 1'b0);    endtask
  task automatic test_wrap();          run_xfer(1022, 4, 0, 1'b0); endtask
  task automatic test_backpressure();  run_xfer(37, 8, 1, 1'b0);   endtask
  task automatic test_zero_len();      run_xfer(5, 0, 0, 1'b0);    endtask
  task automatic test_restart_ignored(); run_xfer(100, 6, 0, 1'b1); endtask

  task automatic test_reset_mid();
    int popped = 0;
    int cyc = 0;
    preload_linear();
    @(negedge clk);
    base_addr = '0; len = LW'(8); start = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (popped < 3 && cyc < 20) begin
      #1;
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== WIDTH'('h100 + popped)) begin
          n_fail++;
          $display("FAIL pre_reset word %0d: got %h want %h", popped, m_data, 'h100 + popped);
        end
        popped++;
      end
      @(negedge clk);
      cyc++;
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, ram_en, ram_we, m_valid, m_last} !== 6'b0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: ctrl=%b data=%h, want 000000 and 0", {busy, done, ram_en, ram_we, m_valid, m_last}, m_data);
    end
    @(negedge clk);
    rstn = 1'b1;
    run_xfer(10, 2, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'($urandom);
    for (int t = 0; t < 8; t++) begin
      run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 24)), 2, 1'b0);
    end
    run_xfer(1000, 40, 2, 1'b0);
    run_xfer(300, DEPTH, 2, 1'b0);
    preload_linear();
  endtask

  initial begin
    preload_linear();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
